fa_requester: RTL

- Initiator/checker for the 8-bit full-adder datapath: drives the adder's A/B/C_in operand side and samples its Sum/C_out result side.
- Accepts operand transactions on a valid/ready request port, holds them on the adder bus for a programmable settle time, then captures the result.
- Checks the captured result against an internally computed reference and returns it on a valid/ready response port.
- Sits between a stimulus source (test-mode controller or DMA-fed operand queue) and the combinational adder instance.

---
 rtl/fa_requester.sv | 118 +++++++++++
 1 files changed

// File: rtl/fa_requester.sv
// Operand initiator and result checker for the combinational full-adder datapath.
// Registers one operand set onto the adder bus, waits a settle time, then captures and checks the result.
module fa_requester #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_cin,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic                 C_in,
  input  logic [WIDTH-1:0]     Sum,
  input  logic                 C_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Wide enough for the largest legal settle time (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] settle_cnt;
  logic             req_fire;
  logic             rsp_fire;
  logic             sample;
  logic [WIDTH:0]   ref_sum;
  logic             mismatch;

  assign req_fire = (state == ST_IDLE) && req_valid && req_ready;
  assign sample   = (state == ST_WAIT) && (settle_cnt == '0);
  assign rsp_fire = (state == ST_RESP) && rsp_ready;

  // Reference is taken from the registered operands, i.e. exactly what the adder sees.
  assign ref_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_in};
  assign mismatch = ({C_out, Sum} != ref_sum);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req_fire) next_state = ST_WAIT;
      ST_WAIT: if (sample)   next_state = ST_RESP;
      ST_RESP: if (rsp_fire) next_state = ST_IDLE;
      default:               next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= next_state;
      // Registered so ready stays low while reset is held and rises one edge after release.
      req_ready <= (next_state == ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A          <= '0;
      B          <= '0;
      C_in       <= 1'b0;
      settle_cnt <= '0;
    end else if (req_fire) begin
      A          <= req_a;
      B          <= req_b;
      C_in       <= req_cin;
      settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state == ST_WAIT) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (sample) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= Sum;
      rsp_cout  <= C_out;
      rsp_err   <= mismatch;
    end else if (rsp_fire) begin
      // Payload is left as-is so the last result stays observable after the handshake.
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (sample && mismatch && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
